// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg -- shared encodings for the multi-cycle RISC-V control path
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       trap;
  } ctrl_t;

  // Moore control word for a state; fields not listed for a state stay 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.addr_src   = ADDR_PC;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_req  = 1'b1;
        c.addr_src = ADDR_ALUOUT;
      end
      S_MEMWR: begin
        c.mem_req  = 1'b1;
        c.mem_we   = 1'b1;
        c.addr_src = ADDR_ALUOUT;
      end
      S_MEMWB: c.result_src = RES_MEMDATA;
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_RTYPE;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ITYPE;
      end
      S_ALUWB: c.result_src = RES_ALUOUT;
      S_BRANCH: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALU_SUB;
        c.result_src = RES_ALUOUT;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALUOUT;
      end
      S_TRAP:  c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// mem_wait_timer -- counts memory wait cycles and flags the last allowed one
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // count holds (cycles already waited in this state) - 1 during the wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = count_en && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// mc_control_fsm -- multi-cycle RISC-V main control FSM with memory timeout
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       trap,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [3:0] state
);

  state_t cur_state;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   running;
  logic   waiting;
  logic   expired;
  logic   branch_legal;
  logic   branch_taken;

  // running stays low until the first edge after reset, keeping outputs quiet
  assign waiting = running &&
                   ((cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR));

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (next_state != cur_state),
    .count_en (waiting),
    .expired  (expired)
  );

  always_comb begin
    branch_legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
    branch_taken = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
  end

  always_comb begin
    next_state = cur_state;
    if (!running) begin
      next_state = S_FETCH;
    end else begin
      case (cur_state)
        S_FETCH: begin
          if (mem_ready)    next_state = S_DECODE;
          else if (expired) next_state = S_TRAP;
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: next_state = S_MEMADR;
            OP_RTYPE:          next_state = S_EXECR;
            OP_ITYPE:          next_state = S_EXECI;
            OP_BRANCH:         next_state = S_BRANCH;
            OP_JAL:            next_state = S_JAL;
            default:           next_state = S_TRAP;
          endcase
        end
        S_MEMADR: next_state = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_ready)    next_state = S_MEMWB;
          else if (expired) next_state = S_TRAP;
        end
        S_MEMWR: begin
          if (mem_ready)    next_state = S_FETCH;
          else if (expired) next_state = S_TRAP;
        end
        S_MEMWB, S_ALUWB: next_state = S_FETCH;
        S_EXECR, S_EXECI: next_state = S_ALUWB;
        S_BRANCH:         next_state = branch_legal ? S_FETCH : S_TRAP;
        S_JAL:            next_state = S_ALUWB;
        default:          next_state = S_TRAP;
      endcase
    end
  end

  // Moore outputs are registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      cur_state <= S_FETCH;
      ctrl_q    <= '0;
    end else begin
      running   <= 1'b1;
      cur_state <= next_state;
      ctrl_q    <= state_ctrl(next_state);
    end
  end

  assign ir_write  = running && (cur_state == S_FETCH) && mem_ready;
  assign pc_write  = ir_write ||
                     (running && (((cur_state == S_BRANCH) && branch_taken) || (cur_state == S_JAL)));
  assign reg_write = running && ((cur_state == S_MEMWB) || (cur_state == S_ALUWB));

  assign mem_req    = ctrl_q.mem_req;
  assign mem_we     = ctrl_q.mem_we;
  assign addr_src   = ctrl_q.addr_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign result_src = ctrl_q.result_src;
  assign trap       = ctrl_q.trap;
  assign state      = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// tb_mc_control_fsm -- directed bench with an instruction-level reference model
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;
  import riscv_pkg::*;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = OP_RTYPE;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_src, pc_write, ir_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mc_control_fsm #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .trap(trap),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {state, mem_req, mem_we, addr_src, alu_src_a, alu_src_b, alu_op,
            result_src, trap, pc_write, ir_write, reg_write};
  endfunction

  // Expected Moore word {mem_req,mem_we,addr_src,a,b,alu_op,result_src,trap}
  function automatic logic [11:0] moore(input state_t s);
    case (s)
      S_FETCH:  return 12'b1_0_0_00_10_00_10_0;
      S_DECODE: return 12'b0_0_0_01_01_00_00_0;
      S_MEMADR: return 12'b0_0_0_10_01_00_00_0;
      S_MEMRD:  return 12'b1_0_1_00_00_00_00_0;
      S_MEMWR:  return 12'b1_1_1_00_00_00_00_0;
      S_MEMWB:  return 12'b0_0_0_00_00_00_01_0;
      S_EXECR:  return 12'b0_0_0_10_00_10_00_0;
      S_EXECI:  return 12'b0_0_0_10_01_11_00_0;
      S_BRANCH: return 12'b0_0_0_10_00_01_00_0;
      S_JAL:    return 12'b0_0_0_01_10_00_00_0;
      S_TRAP:   return 12'b0_0_0_00_00_00_00_1;
      default:  return 12'b0;
    endcase
  endfunction

  // Reference model: phases of the current instruction are queued at decode
  state_t      m_state = S_FETCH;
  bit          m_run = 1'b0;
  int          m_wait = 0;
  state_t      route[$];
  state_t      m_nxt;
  logic        m_pcw, m_irw, m_rgw;
  logic [18:0] exp_v;

  function automatic state_t pop_next();
    if (route.size() == 0) return S_FETCH;
    return route.pop_front();
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_v = '0; m_run = 1'b0; m_state = S_FETCH; m_wait = 0; route.delete();
    end else if (!m_run) begin
      exp_v = '0; m_run = 1'b1; m_state = S_FETCH; m_wait = 0;
    end else begin
      m_pcw = 1'b0; m_irw = 1'b0; m_rgw = 1'b0; m_nxt = m_state;
      if (m_state == S_FETCH || m_state == S_MEMRD || m_state == S_MEMWR) begin
        m_wait++;
        if (mem_ready) begin
          if (m_state == S_FETCH) begin m_pcw = 1'b1; m_irw = 1'b1; m_nxt = S_DECODE; end
          else m_nxt = pop_next();
        end else if (m_wait >= TO) m_nxt = S_TRAP;
      end else if (m_state == S_DECODE) begin
        route.delete();
        if (opcode == OP_LOAD)        begin route.push_back(S_MEMADR); route.push_back(S_MEMRD); route.push_back(S_MEMWB); end
        else if (opcode == OP_STORE)  begin route.push_back(S_MEMADR); route.push_back(S_MEMWR); end
        else if (opcode == OP_RTYPE)  begin route.push_back(S_EXECR); route.push_back(S_ALUWB); end
        else if (opcode == OP_ITYPE)  begin route.push_back(S_EXECI); route.push_back(S_ALUWB); end
        else if (opcode == OP_BRANCH) route.push_back(S_BRANCH);
        else if (opcode == OP_JAL)    begin route.push_back(S_JAL); route.push_back(S_ALUWB); end
        else                          route.push_back(S_TRAP);
        m_nxt = pop_next();
      end else if (m_state == S_BRANCH) begin
        if (funct3 == 3'b000)      begin m_pcw = zero;  m_nxt = pop_next(); end
        else if (funct3 == 3'b001) begin m_pcw = !zero; m_nxt = pop_next(); end
        else m_nxt = S_TRAP;
      end else if (m_state == S_TRAP) begin
        m_nxt = S_TRAP;
      end else begin
        if (m_state == S_MEMWB || m_state == S_ALUWB) m_rgw = 1'b1;
        if (m_state == S_JAL) m_pcw = 1'b1;
        m_nxt = pop_next();
      end
      exp_v = {m_state, moore(m_state), m_pcw, m_irw, m_rgw};
      if (m_nxt != m_state) m_wait = 0;
      m_state = m_nxt;
    end
    check("cycle", {13'b0, outs()}, {13'b0, exp_v});
  end

  int         r_cycles, n_regw, regw_cyc, n_pcw, n_addr1;
  logic [3:0] r_end;
  logic [1:0] op_c3, wb_res;
  logic       wb_rw;

  // Caller is 1 time unit after a rising edge with the DUT in FETCH
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input int mwait);
    int c, waited;
    opcode = op; funct3 = f3; zero = z;
    c = 0; waited = 0; n_regw = 0; regw_cyc = 0; n_pcw = 0; n_addr1 = 0;
    op_c3 = 2'bxx; wb_res = 2'bxx; wb_rw = 1'bx;
    while (c < 40) begin
      c++;
      if (state == S_MEMRD || state == S_MEMWR) begin mem_ready = (waited >= mwait); waited++; end
      else mem_ready = 1'b1;
      #1;
      if (reg_write) begin n_regw++; regw_cyc = c; end
      if (pc_write) n_pcw++;
      if (mem_req && addr_src) n_addr1++;
      if (c == 3) op_c3 = alu_op;
      if (state == S_MEMWB) begin wb_res = result_src; wb_rw = reg_write; end
      @(posedge clk); #1;
      if (state == S_FETCH || state == S_TRAP) break;
    end
    r_cycles = c; r_end = state;
  endtask

  task automatic fetch_wait(input int n_low);
    int c;
    c = 0;
    while (c < 40) begin
      c++;
      mem_ready = (c > n_low);
      @(posedge clk); #1;
      if (state != S_FETCH) break;
    end
    r_cycles = c; r_end = state;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b1;
    #1 check("rst_async_outputs", {13'b0, outs()}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_release_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    check("first_edge_fetch_req", {31'b0, mem_req}, 32'd1);
  endtask

  initial begin
    int held;
    #3 check("reset_outputs", {13'b0, outs()}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_release_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    check("first_edge_fetch_req", {31'b0, mem_req}, 32'd1);

    run_instr(OP_RTYPE, 3'b000, 1'b0, 0);
    check("add_cycles", r_cycles, 4);
    check("add_end", {28'b0, r_end}, S_FETCH);
    check("add_regw_count", n_regw, 1);
    check("add_regw_cycle", regw_cyc, 4);
    check("add_aluop_execr", {30'b0, op_c3}, 32'd2);

    run_instr(OP_ITYPE, 3'b000, 1'b0, 0);
    check("addi_cycles", r_cycles, 4);
    check("addi_aluop_execi", {30'b0, op_c3}, 32'd3);

    run_instr(OP_LOAD, 3'b010, 1'b0, 3);
    check("load_wait_cycles", r_cycles, 8);
    check("load_wait_addr1", n_addr1, 4);
    check("load_wb_result_src", {30'b0, wb_res}, 32'd1);
    check("load_wb_regw", {31'b0, wb_rw}, 32'd1);

    run_instr(OP_LOAD, 3'b010, 1'b0, 0);
    check("load_cycles", r_cycles, 5);

    run_instr(OP_STORE, 3'b010, 1'b0, 0);
    check("store_cycles", r_cycles, 4);
    check("store_regw_count", n_regw, 0);

    run_instr(OP_BRANCH, 3'b000, 1'b1, 0);
    check("beq_taken_cycles", r_cycles, 3);
    check("beq_taken_pcw", n_pcw, 2);
    check("beq_aluop", {30'b0, op_c3}, 32'd1);
    run_instr(OP_BRANCH, 3'b001, 1'b1, 0);
    check("bne_nt_pcw", n_pcw, 1);
    check("bne_nt_end", {28'b0, r_end}, S_FETCH);
    run_instr(OP_BRANCH, 3'b001, 1'b0, 0);
    check("bne_taken_pcw", n_pcw, 2);
    run_instr(OP_BRANCH, 3'b000, 1'b0, 0);
    check("beq_nt_pcw", n_pcw, 1);

    run_instr(OP_JAL, 3'b000, 1'b0, 0);
    check("jal_cycles", r_cycles, 4);
    check("jal_pcw", n_pcw, 2);
    check("jal_regw", n_regw, 1);

    run_instr(OP_BRANCH, 3'b010, 1'b1, 0);
    check("badf3_cycles", r_cycles, 3);
    check("badf3_end", {28'b0, r_end}, S_TRAP);
    check("badf3_pcw", n_pcw, 1);
    do_reset();

    run_instr(7'b1110011, 3'b000, 1'b0, 0);
    check("illegal_cycles", r_cycles, 2);
    check("illegal_end", {28'b0, r_end}, S_TRAP);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (state == S_TRAP && trap && !mem_req && !pc_write) held++;
    end
    check("trap_held_20", held, 20);
    do_reset();
    check("trap_reset_fetch", {28'b0, state}, S_FETCH);

    opcode = OP_RTYPE;
    fetch_wait(100);
    check("fetch_timeout_cycles", r_cycles, 15);
    check("fetch_timeout_end", {28'b0, r_end}, S_TRAP);
    do_reset();
    fetch_wait(14);
    check("fetch_last_cycle_cycles", r_cycles, 15);
    check("fetch_last_cycle_end", {28'b0, r_end}, S_DECODE);
    do_reset();

    run_instr(OP_STORE, 3'b010, 1'b0, 100);
    check("memwr_timeout_cycles", r_cycles, 18);
    check("memwr_timeout_end", {28'b0, r_end}, S_TRAP);
    do_reset();

    opcode = OP_STORE; mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("in_memwr", {28'b0, state}, S_MEMWR);
    check("memwr_we", {31'b0, mem_we}, 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=running expected=done");
    $fatal(1);
  end

endmodule

`default_nettype wire
